// File: rtl/hv_ang_val_sample_mc.sv
// Per-channel analog readback sampler: settle, average 2^AVG_LOG2 samples, store per channel.
// Latency 1+SETL_CYC+2^AVG_LOG2+1 cycles from a valid one-hot select; any select change aborts.
module hv_ang_val_sample_mc #(
   parameter int CH_NUM   = 4,
   parameter int DW       = 8,
   parameter int SETL_CYC = 4,
   parameter int AVG_LOG2 = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [CH_NUM-1:0]    i_tm_sel,
   input  logic                 i_cont_mode,
   input  logic [CH_NUM*DW-1:0] i_ana_val,
   output logic [CH_NUM*DW-1:0] o_val_read,
   output logic [CH_NUM-1:0]    o_val_vld,
   output logic                 o_busy,
   output logic                 o_upd_pls
);

   localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
   localparam int SC_W = (SETL_CYC > 1) ? $clog2(SETL_CYC) : 1;
   localparam int AC_W = AVG_LOG2 + 1;
   localparam int AW   = DW + AVG_LOG2;
   localparam logic [SC_W-1:0] SETL_LAST = SC_W'(SETL_CYC - 1);
   localparam logic [AC_W-1:0] N_SMP     = AC_W'(1 << AVG_LOG2);

   typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, DONE} state_t;

   state_t               state_q, state_d;
   logic [CH_W-1:0]      cur_ch_q, cur_ch_d;
   logic [CH_NUM-1:0]    sel_q, sel_d;
   logic [SC_W-1:0]      scnt_q, scnt_d;
   logic [AC_W-1:0]      acnt_q, acnt_d;
   logic [AW-1:0]        acc_q, acc_d;
   logic [CH_NUM*DW-1:0] val_q, val_d;
   logic [CH_NUM-1:0]    vld_q, vld_d;
   logic                 busy_q, busy_d;
   logic                 upd_q, upd_d;

   logic                 sel_ok;
   logic [CH_W-1:0]      sel_idx;
   logic [DW-1:0]        smp;

   always_comb begin
      sel_idx = '0;
      for (int k = 0; k < CH_NUM; k++) begin
         if (i_tm_sel[k]) sel_idx = CH_W'(k);
      end
      sel_ok = $onehot(i_tm_sel);
   end

   always_comb begin
      smp = '0;
      for (int k = 0; k < CH_NUM; k++) begin
         if (CH_W'(k) == cur_ch_q) smp = i_ana_val[k*DW +: DW];
      end
   end

   always_comb begin
      state_d  = state_q;
      cur_ch_d = cur_ch_q;
      sel_d    = sel_q;
      scnt_d   = scnt_q;
      acnt_d   = acnt_q;
      acc_d    = acc_q;
      val_d    = val_q;
      vld_d    = vld_q;
      upd_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (sel_ok) begin
               state_d  = SETTLE;
               cur_ch_d = sel_idx;
               sel_d    = i_tm_sel;
               scnt_d   = '0;
            end
         end
         SETTLE: begin
            if (scnt_q == SETL_LAST) begin
               state_d = ACCUM;
               acnt_d  = '0;
               acc_d   = '0;
            end else begin
               scnt_d = scnt_q + SC_W'(1);
            end
         end
         ACCUM: begin
            // Extra cycle after the last sample is the write cycle
            if (acnt_q == N_SMP) begin
               for (int k = 0; k < CH_NUM; k++) begin
                  if (CH_W'(k) == cur_ch_q) begin
                     val_d[k*DW +: DW] = acc_q[AVG_LOG2 +: DW];
                     vld_d[k]          = 1'b1;
                  end
               end
               upd_d  = 1'b1;
               acnt_d = '0;
               acc_d  = '0;
               if (!i_cont_mode) state_d = DONE;
            end else begin
               acc_d  = acc_q + AW'(smp);
               acnt_d = acnt_q + AC_W'(1);
            end
         end
         default: ;
      endcase

      // A select change discards any pending write; a new valid select restarts directly
      if (state_q != IDLE && i_tm_sel != sel_q) begin
         val_d = val_q;
         vld_d = vld_q;
         upd_d = 1'b0;
         if (sel_ok) begin
            state_d  = SETTLE;
            cur_ch_d = sel_idx;
            sel_d    = i_tm_sel;
            scnt_d   = '0;
         end else begin
            state_d = IDLE;
         end
      end

      busy_d = (state_d == SETTLE) || (state_d == ACCUM);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= IDLE;
         cur_ch_q <= '0;
         sel_q    <= '0;
         scnt_q   <= '0;
         acnt_q   <= '0;
         acc_q    <= '0;
         val_q    <= '0;
         vld_q    <= '0;
         busy_q   <= 1'b0;
         upd_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cur_ch_q <= cur_ch_d;
         sel_q    <= sel_d;
         scnt_q   <= scnt_d;
         acnt_q   <= acnt_d;
         acc_q    <= acc_d;
         val_q    <= val_d;
         vld_q    <= vld_d;
         busy_q   <= busy_d;
         upd_q    <= upd_d;
      end
   end

   assign o_val_read = val_q;
   assign o_val_vld  = vld_q;
   assign o_busy     = busy_q;
   assign o_upd_pls  = upd_q;

endmodule

// File: tb/tb_hv_ang_val_sample_mc.sv
// Bench for hv_ang_val_sample_mc: table of conversions plus abort, invalid, continuous and reset sequences.
// Expected writes (channel, value, cycle) are queued at stimulus time and popped on each update pulse.
module tb_hv_ang_val_sample_mc;

   logic        clk;
   logic        rst;
   logic [3:0]  sel;
   logic        cont;
   logic [31:0] ana;
   logic [31:0] val_read;
   logic [3:0]  val_vld;
   logic        busy;
   logic        upd;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      int         ch;
      logic [7:0] s [4];
      logic [7:0] exp;
   } vec_t;

   typedef struct {
      int         ch;
      logic [7:0] val;
      int         cyc;
   } exp_t;

   exp_t        q [$];
   logic [31:0] m_val;
   logic [3:0]  m_vld;

   hv_ang_val_sample_mc #(.CH_NUM(4), .DW(8), .SETL_CYC(4), .AVG_LOG2(2)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_tm_sel    (sel),
      .i_cont_mode (cont),
      .i_ana_val   (ana),
      .o_val_read  (val_read),
      .o_val_vld   (val_vld),
      .o_busy      (busy),
      .o_upd_pls   (upd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h cyc=%0d", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Scoreboard: every update pulse must match the next queued write, and outputs must match the model
   always @(negedge clk) begin
      if (!rst) begin
         if (upd) begin
            if (q.size() == 0) begin
               chk("unexpected_write", 64'(val_read), 64'(m_val));
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("write_cycle", 64'(cyc), 64'(e.cyc));
               m_val[e.ch*8 +: 8] = e.val;
               m_vld[e.ch]        = 1'b1;
            end
         end
         chk("val_read", 64'(val_read), 64'(m_val));
         chk("val_vld", 64'(val_vld), 64'(m_vld));
      end
   end

   task automatic run_conv(input vec_t v);
      exp_t e;
      sel   = 4'(1 << v.ch);
      e.ch  = v.ch;
      e.val = v.exp;
      e.cyc = cyc + 10;
      q.push_back(e);
      tick(1);
      chk("busy_settle", 64'(busy), 64'd1);
      tick(4);
      for (int i = 0; i < 4; i++) begin
         ana = $urandom;
         ana[v.ch*8 +: 8] = v.s[i];
         tick(1);
      end
      tick(1);
      chk("busy_done", 64'(busy), 64'd0);
      tick(6);
      sel = 4'b0000;
      tick(2);
   endtask

   initial begin
      vec_t tbl [6];
      vec_t rv;
      exp_t e;
      int   c0;
      int   sum;

      tbl[0].ch = 1; tbl[0].s = '{8'h5A, 8'h5A, 8'h5A, 8'h5A}; tbl[0].exp = 8'h5A;
      tbl[1].ch = 2; tbl[1].s = '{8'd10, 8'd11, 8'd12, 8'd14}; tbl[1].exp = 8'd11;
      tbl[2].ch = 2; tbl[2].s = '{8'hFF, 8'hFF, 8'hFF, 8'hFF}; tbl[2].exp = 8'hFF;
      tbl[3].ch = 0; tbl[3].s = '{8'd0,  8'd1,  8'd2,  8'd3};  tbl[3].exp = 8'd1;
      tbl[4].ch = 3; tbl[4].s = '{8'h80, 8'h81, 8'h7F, 8'h00}; tbl[4].exp = 8'h60;
      tbl[5].ch = 0; tbl[5].s = '{8'd3,  8'd3,  8'd3,  8'd2};  tbl[5].exp = 8'd2;

      rst   = 1'b1;
      sel   = 4'b0000;
      cont  = 1'b0;
      ana   = '0;
      m_val = '0;
      m_vld = '0;
      tick(2);
      chk("rst_val", 64'(val_read), 64'd0);
      chk("rst_vld", 64'(val_vld), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_upd", 64'(upd), 64'd0);
      rst = 1'b0;
      tick(2);

      for (int i = 0; i < 6; i++) run_conv(tbl[i]);

      // Invalid selects: nothing starts
      sel = 4'b0011;
      for (int i = 0; i < 8; i++) begin
         ana = $urandom;
         tick(1);
         chk("inval_multi_busy", 64'(busy), 64'd0);
      end
      sel = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         chk("inval_zero_busy", 64'(busy), 64'd0);
      end

      // Abort ch0 in ACCUM by switching to ch2
      sel = 4'b0001;
      ana = $urandom;
      tick(7);
      chk("abort_busy_accum", 64'(busy), 64'd1);
      sel = 4'b0100;
      ana = $urandom;
      ana[23:16] = 8'h33;
      e.ch = 2; e.val = 8'h33; e.cyc = cyc + 10;
      q.push_back(e);
      tick(12);
      sel = 4'b0000;
      tick(2);

      // Continuous mode on ch3 with a ramp; cont cleared during the fourth conversion
      c0   = cyc;
      cont = 1'b1;
      sel  = 4'b1000;
      for (int j = 0; j < 4; j++) begin
         sum = 0;
         for (int t = 5 + 5*j; t <= 8 + 5*j; t++) sum += 3*t;
         e.ch = 3; e.val = 8'(sum >> 2); e.cyc = c0 + 10 + 5*j;
         q.push_back(e);
      end
      for (int t = 0; t < 30; t++) begin
         ana = $urandom;
         ana[31:24] = 8'(3*t);
         if (t == 20) cont = 1'b0;
         tick(1);
         if (t <= 23) chk("cont_busy", 64'(busy), 64'd1);
         else         chk("cont_done_busy", 64'(busy), 64'd0);
      end
      sel = 4'b0000;
      tick(2);

      // Reset during SETTLE discards everything
      sel = 4'b0010;
      tick(3);
      chk("pre_rst_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_val", 64'(val_read), 64'd0);
      chk("mid_rst_vld", 64'(val_vld), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_upd", 64'(upd), 64'd0);
      m_val = '0;
      m_vld = '0;
      q.delete();
      tick(2);
      sel = 4'b0000;
      rst = 1'b0;
      tick(2);
      rv.ch = 1; rv.s = '{8'h21, 8'h22, 8'h23, 8'h24}; rv.exp = 8'h22;
      run_conv(rv);

      chk("queue_empty", 64'(q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
